// File: rtl/hyperbus_rwds_delay_trainer.sv
// RWDS receive delay-line calibration: sweeps all 8 taps with pattern reads and
// programs the delay line to the centre of the longest passing window.
module hyperbus_rwds_delay_trainer #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned DEFAULT_TAP    = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic       busy_o,
  output logic       test_req_o,
  output logic [2:0] test_tap_o,
  input  logic       test_done_i,
  input  logic       test_pass_i,
  output logic [7:0] delay_sel_o,
  output logic [2:0] tap_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int unsigned TAPW = 3;
  localparam int unsigned SELW = 8;
  localparam int unsigned LENW = 4;
  localparam int unsigned SCW  = 8;
  localparam int unsigned TCW  = 16;

  localparam logic [TAPW-1:0] LAST_TAP = TAPW'(7);
  localparam logic [TAPW-1:0] DEF_TAP  = TAPW'(DEFAULT_TAP);
  localparam logic [SCW-1:0]  SETTLE_LAST  = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TCW-1:0]  TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  // One-hot select for taps 0..6; the last tap is the all-zero (minimum) code.
  function automatic logic [SELW-1:0] tap_code(input logic [TAPW-1:0] k);
    tap_code = (k == LAST_TAP) ? '0 : (SELW'(1) << k);
  endfunction

  localparam logic [SELW-1:0] DEF_SEL = tap_code(DEF_TAP);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    TEST,
    EVAL,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [TAPW-1:0] cur_tap_q, cur_tap_d;
  logic [SCW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [TCW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic            pass_q, pass_d;
  logic [LENW-1:0] run_len_q, run_len_d;
  logic [TAPW-1:0] run_start_q, run_start_d;
  logic [LENW-1:0] best_len_q, best_len_d;
  logic [TAPW-1:0] best_start_q, best_start_d;
  logic            busy_d, test_req_d, done_d, error_d;
  logic [TAPW-1:0] test_tap_d, tap_d;
  logic [SELW-1:0] sel_d;

  logic [LENW-1:0] run_len_nxt;
  logic [TAPW-1:0] run_start_nxt;
  logic [TAPW-1:0] centre_tap;

  // Run bookkeeping for the tap just evaluated.
  always_comb begin
    run_len_nxt   = pass_q ? LENW'(run_len_q + LENW'(1)) : '0;
    run_start_nxt = (pass_q && (run_len_q == '0)) ? cur_tap_q : run_start_q;
    centre_tap    = TAPW'(best_start_q + TAPW'((best_len_q - LENW'(1)) >> 1));
  end

  always_comb begin
    state_d      = state_q;
    cur_tap_d    = cur_tap_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    pass_d       = pass_q;
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    busy_d       = busy_o;
    test_req_d   = test_req_o;
    test_tap_d   = test_tap_o;
    tap_d        = tap_o;
    sel_d        = delay_sel_o;
    error_d      = error_o;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = APPLY;
          busy_d       = 1'b1;
          error_d      = 1'b0;
          cur_tap_d    = '0;
          run_len_d    = '0;
          run_start_d  = '0;
          best_len_d   = '0;
          best_start_d = '0;
        end
      end
      APPLY: begin
        tap_d        = cur_tap_q;
        sel_d        = tap_code(cur_tap_q);
        settle_cnt_d = '0;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d    = TEST;
          test_req_d = 1'b1;
          test_tap_d = cur_tap_q;
          tmo_cnt_d  = '0;
        end else begin
          settle_cnt_d = SCW'(settle_cnt_q + SCW'(1));
        end
      end
      // A completion in the expiry cycle still counts: done has priority.
      TEST: begin
        if (test_done_i) begin
          pass_d     = test_pass_i;
          test_req_d = 1'b0;
          state_d    = EVAL;
        end else if (tmo_cnt_q == TIMEOUT_LAST) begin
          pass_d     = 1'b0;
          test_req_d = 1'b0;
          state_d    = EVAL;
        end else begin
          tmo_cnt_d = TCW'(tmo_cnt_q + TCW'(1));
        end
      end
      EVAL: begin
        run_len_d   = run_len_nxt;
        run_start_d = run_start_nxt;
        if (run_len_nxt > best_len_q) begin
          best_len_d   = run_len_nxt;
          best_start_d = run_start_nxt;
        end
        if (cur_tap_q == LAST_TAP) begin
          state_d = FINISH;
        end else begin
          cur_tap_d = TAPW'(cur_tap_q + TAPW'(1));
          state_d   = APPLY;
        end
      end
      FINISH: begin
        if (best_len_q != '0) begin
          tap_d = centre_tap;
          sel_d = tap_code(centre_tap);
        end else begin
          tap_d   = DEF_TAP;
          sel_d   = DEF_SEL;
          error_d = 1'b1;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cur_tap_q    <= '0;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      pass_q       <= 1'b0;
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      busy_o       <= 1'b0;
      test_req_o   <= 1'b0;
      test_tap_o   <= '0;
      tap_o        <= DEF_TAP;
      delay_sel_o  <= DEF_SEL;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_tap_q    <= cur_tap_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      pass_q       <= pass_d;
      run_len_q    <= run_len_d;
      run_start_q  <= run_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      busy_o       <= busy_d;
      test_req_o   <= test_req_d;
      test_tap_o   <= test_tap_d;
      tap_o        <= tap_d;
      delay_sel_o  <= sel_d;
      done_o       <= done_d;
      error_o      <= error_d;
    end
  end

endmodule
